// File: rtl/c7bifu_ibuf_if.sv
// Fetch-return / decode-head bundle between the ICU, fetch control, EXU and the
// instruction buffer. The buffer takes the slave side.
interface c7bifu_ibuf_if #(
  parameter int DW = 32
);
  logic          icu_ifu_ack_ic1;
  logic          icu_ifu_data_valid_ic2;
  logic [DW-1:0] icu_ifu_inst_ic2;
  logic [DW-1:0] ifu_pc_ic2;
  logic          exu_ifu_except;
  logic          exu_ifu_branch;
  logic          exu_ifu_ertn;
  logic          exu_ifu_stall;
  logic          ifu_exu_valid_d;
  logic [DW-1:0] ifu_exu_inst_d;
  logic [DW-1:0] ifu_exu_pc_d;
  logic          ifu_fcl_ibuf_full;
  logic          ifu_ibuf_ovf;

  modport master (
    output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_inst_ic2, ifu_pc_ic2,
           exu_ifu_except, exu_ifu_branch, exu_ifu_ertn, exu_ifu_stall,
    input  ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d, ifu_fcl_ibuf_full, ifu_ibuf_ovf
  );

  modport slave (
    input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_inst_ic2, ifu_pc_ic2,
           exu_ifu_except, exu_ifu_branch, exu_ifu_ertn, exu_ifu_stall,
    output ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d, ifu_fcl_ibuf_full, ifu_ibuf_ovf
  );
endinterface

// File: rtl/c7bifu_ibuf.sv
// Instruction buffer: FIFO of ic2 returns feeding decode, with outstanding-request
// tracking, post-flush stale-return dropping and fetch back-pressure.
module c7bifu_ibuf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  c7bifu_ibuf_if.slave     ibuf
);
  localparam int SW = PTR_W + 3;

  logic [DW-1:0]    memInst_q [DEPTH];
  logic [DW-1:0]    memPc_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       outst_q, outst_d;
  logic [1:0]       drop_q;
  logic             ovf_q;

  logic flush, validHead, pop, push, dropping, isFull, ovfEvent;
  logic [SW-1:0] occupancy;

  assign flush     = ibuf.exu_ifu_except | ibuf.exu_ifu_branch | ibuf.exu_ifu_ertn;
  assign validHead = (count_q != '0);
  assign isFull    = (count_q == (PTR_W+1)'(DEPTH));
  assign dropping  = (drop_q != 2'd0);
  assign pop       = validHead & ~ibuf.exu_ifu_stall & ~flush;
  assign push      = ibuf.icu_ifu_data_valid_ic2 & ~flush & ~dropping & (~isFull | pop);
  assign ovfEvent  = ibuf.icu_ifu_data_valid_ic2 & ~flush & ~dropping & isFull & ~pop;

  // Outstanding requests saturate at both ends rather than wrapping.
  always_comb begin
    outst_d = outst_q;
    if (ibuf.icu_ifu_ack_ic1 && !ibuf.icu_ifu_data_valid_ic2 && outst_q != 2'd3)
      outst_d = outst_q + 2'd1;
    else if (!ibuf.icu_ifu_ack_ic1 && ibuf.icu_ifu_data_valid_ic2 && outst_q != 2'd0)
      outst_d = outst_q - 2'd1;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push)
      count_d = count_q - (PTR_W+1)'(1);
  end

  // Storage is not reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      memInst_q[wr_ptr_q] <= ibuf.icu_ifu_inst_ic2;
      memPc_q[wr_ptr_q]   <= ibuf.ifu_pc_ic2;
    end
  end

  // On a flush everything still in flight (including a same-cycle ack) becomes stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= 2'd0;
      drop_q   <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        drop_q   <= outst_d;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_d;
        if (dropping && ibuf.icu_ifu_data_valid_ic2)
          drop_q <= drop_q - 2'd1;
      end
      if (ovfEvent)
        ovf_q <= 1'b1;
    end
  end

  assign occupancy = SW'(count_q) + SW'(outst_q);

  assign ibuf.ifu_exu_valid_d   = validHead;
  assign ibuf.ifu_exu_inst_d    = memInst_q[rd_ptr_q];
  assign ibuf.ifu_exu_pc_d      = memPc_q[rd_ptr_q];
  assign ibuf.ifu_fcl_ibuf_full = (occupancy >= SW'(DEPTH - 1));
  assign ibuf.ifu_ibuf_ovf      = ovf_q;
endmodule
